trig_capture: RTL and testbench
===============================

# trig_capture

Trigger-and-capture buffer sitting between the ADC sampling stage and the serial sending stage of the scope. It writes CH1 samples into a circular buffer on each ADC sample strobe and detects a rising or falling crossing of a trigger level. It then freezes a window holding PRE_TRIG samples before the trigger and the remainder after it. The frozen window is replayed to the sender over a valid/ready handshake, once per arm (single mode) or continuously (auto mode).

## Interface
Parameters:
- DATA_W, 12, sample width (matches ADC bus)
- ADDR_W, 8, buffer address width; DEPTH = 2^ADDR_W = 256 samples
- PRE_TRIG, 64, samples kept before the trigger sample; legal range 1..DEPTH-1

Ports:
- sys_clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- sample_en  in  1  one-cycle strobe, adc_data valid (ADC flag already synchronised to sys_clk)
- adc_data  in  DATA_W  sample
- trig_level  in  DATA_W  trigger threshold, unsigned
- edge_sel  in  1  0 = rising, 1 = falling (edge key flag)
- arm  in  1  one-cycle pulse, start capture from IDLE
- single_mode  in  1  1 = return to IDLE after readout; 0 = auto re-arm
- stop  in  1  level; abort capture / suppress re-arm
- rd_ready  in  1  sender accepts rd_data
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  replayed sample
- rd_last  out  1  qualifies final word of the window
- triggered  out  1  one-cycle pulse on trigger detection
- state  out  3  current FSM state (debug/LED)

## Operation
- States: IDLE=0, PRE=1, WAIT=2, POST=3, READ=4.
- IDLE: arm pulse with stop=0 -> PRE; wr_ptr, counters, prev-valid cleared. arm with stop=1, or arm in any other state: ignored.
- PRE/WAIT/POST: each sample_en writes adc_data to mem[wr_ptr] and increments wr_ptr mod DEPTH. prev_sample <= adc_data, prev_valid <= 1.
- PRE: counts samples; after the PRE_TRIG-th write -> WAIT. No trigger detection in PRE.
- WAIT: trigger on a sample_en where prev_valid and:
  - rising: prev < trig_level and adc_data >= trig_level;
  - falling: prev > trig_level and adc_data <= trig_level.
  On trigger: trig_ptr <= wr_ptr (address of trigger sample), triggered pulses, post_cnt <= 1, -> POST. Ring overwrite continues while waiting.
- POST: post_cnt increments per write. When post_cnt reaches DEPTH-PRE_TRIG -> READ with rd_ptr <= (trig_ptr - PRE_TRIG) mod DEPTH.
- READ: sample_en ignored (buffer frozen). Emits exactly DEPTH words from rd_ptr upward, wrapping mod DEPTH. rd_last is high with word DEPTH-1.
- After the last accepted word: single_mode=1 or stop=1 -> IDLE; otherwise -> PRE (fresh capture, counters cleared).
- stop=1 in PRE/WAIT/POST -> IDLE at next edge, no readout. stop in READ does not abort; the window completes first.
- Memory contents are not reset and are unobservable until fully rewritten.

## Timing
- Reset: state=IDLE, rd_valid=0, rd_data=0, rd_last=0, triggered=0, pointers/counters 0, prev_valid=0.
- Buffer is synchronous-read RAM (1-cycle latency). rd_valid first rises 2 cycles after entering READ.
- Handshake: transfer occurs on an edge with rd_valid&rd_ready. rd_data/rd_last hold stable while rd_valid&!rd_ready. After each transfer rd_valid is low for exactly 1 cycle, then high with the next word. rd_valid deasserts after the last transfer.
- triggered is high in the cycle after the triggering sample_en; state reads POST in the same cycle.
- A sample_en coinciding with a state transition is handled by the state valid before the edge; no samples are dropped at PRE->WAIT or WAIT->POST.
- Async reset mid-READ: rd_valid drops immediately; no partial window resumes.

## Test plan
- Ramp 0,1,2,… on sample_en every 4 cycles; trig_level=100, edge_sel=0, single_mode=1, arm; hold rd_ready=1 -> triggered once at sample 100. Exactly 256 words 36..291 (mod 4096), rd_last only on 291, then state=IDLE.
- Same setup, falling edge, descending ramp 400→0, level 200 -> trigger at 200. Words 264 down to 9, first word 264.
- rd_ready toggled pseudo-randomly -> identical word sequence, no duplicates or drops, rd_data stable while stalled.
- single_mode=0, constant ramp -> second window starts automatically after rd_last. Assert stop during the second WAIT -> IDLE, no rd_valid.
- Input equals trig_level from the first sample (flat 100) -> no trigger; state stays WAIT. arm pulses in WAIT are ignored.
- Assert rst_n low during READ after 10 words -> all outputs 0 asynchronously, state IDLE. Re-arm yields a full 256-word window.

Source files
------------

// File: rtl/trig_capture.sv
// trig_capture: ring-buffer capture around a level-crossing trigger, replayed over valid/ready
module trig_capture #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int PRE_TRIG = 64
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              edge_sel,
  input  logic              arm,
  input  logic              single_mode,
  input  logic              stop,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              triggered,
  output logic [2:0]        state
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, READ = 3'd4;
  localparam logic [ADDR_W:0]   DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   POST_N     = DEPTH_C - (ADDR_W+1)'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_P      = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_N1     = ADDR_W'(PRE_TRIG - 1);
  localparam logic              SHORT_POST = PRE_TRIG == (1 << ADDR_W) - 1;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, pre_cnt_q, pre_cnt_d, trig_ptr_q, trig_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d, post_inc, iss_cnt_q, iss_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d, rd_data_q, rd_data_d;
  logic prev_valid_q, prev_valid_d, first_q, first_d, ram_vld_q, ram_vld_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, triggered_q, triggered_d;
  logic capturing, wr_en, hit, trig, xfer, done, issue, post_done, to_read, start;

  // Next-state logic: capture sequencing, trigger detection and the replay pipeline
  always_comb begin
    capturing = state_q == PRE || state_q == WAIT || state_q == POST;
    wr_en     = capturing && sample_en;
    hit       = edge_sel ? (prev_q > trig_level && adc_data <= trig_level)
                         : (prev_q < trig_level && adc_data >= trig_level);
    trig      = state_q == WAIT && sample_en && prev_valid_q && hit && !stop;
    xfer      = rd_valid_q && rd_ready;
    done      = xfer && rd_last_q;
    issue     = state_q == READ && (first_q || (xfer && !rd_last_q));
    post_inc  = post_cnt_q + 1'b1;
    post_done = state_q == POST && sample_en && !stop && post_inc == POST_N;
    to_read   = (trig && SHORT_POST) || post_done;
    state_d   = state_q;
    if (state_q == IDLE && arm && !stop) state_d = PRE;
    else if (capturing && stop) state_d = IDLE;
    else if (state_q == PRE && sample_en && pre_cnt_q == PRE_N1) state_d = WAIT;
    else if (to_read) state_d = READ;
    else if (trig) state_d = POST;
    else if (done) state_d = (single_mode || stop) ? IDLE : PRE;
    start        = state_d == PRE && state_q != PRE;
    wr_ptr_d     = start ? '0 : wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    pre_cnt_d    = start ? '0 : (state_q == PRE && sample_en) ? pre_cnt_q + 1'b1 : pre_cnt_q;
    post_cnt_d   = start ? '0 : trig ? (ADDR_W+1)'(1) : (state_q == POST && sample_en) ? post_inc : post_cnt_q;
    prev_d       = wr_en ? adc_data : prev_q;
    prev_valid_d = start ? 1'b0 : wr_en ? 1'b1 : prev_valid_q;
    trig_ptr_d   = trig ? wr_ptr_q : trig_ptr_q;
    rd_ptr_d     = to_read ? (state_q == WAIT ? wr_ptr_q : trig_ptr_q) - PRE_P
                 : issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    iss_cnt_d    = to_read ? '0 : issue ? iss_cnt_q + 1'b1 : iss_cnt_q;
    first_d      = to_read;
    ram_vld_d    = issue;
    rd_valid_d   = ram_vld_q ? 1'b1 : xfer ? 1'b0 : rd_valid_q;
    rd_data_d    = ram_vld_q ? ram_q : rd_data_q;
    rd_last_d    = ram_vld_q ? iss_cnt_q == DEPTH_C : xfer ? 1'b0 : rd_last_q;
    triggered_d  = trig;
  end

  // Sample buffer: write port during capture, registered read port during replay
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= adc_data;
    if (issue) ram_q <= mem[rd_ptr_q];
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      iss_cnt_q    <= '0;
      first_q      <= 1'b0;
      ram_vld_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      triggered_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_ptr_q   <= trig_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      iss_cnt_q    <= iss_cnt_d;
      first_q      <= first_d;
      ram_vld_q    <= ram_vld_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      triggered_q  <= triggered_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign triggered = triggered_q;
  assign state     = state_q;
endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture: directed capture windows with hand-computed expectations
module tb_trig_capture;
  logic sys_clk = 1'b0;
  logic rst_n, sample_en, edge_sel, arm, single_mode, stop, rd_ready;
  logic rd_valid, rd_last, triggered, feed_on;
  logic [11:0] adc_data, trig_level, rd_data;
  logic [2:0] state;
  int fstart, fstep;
  int checks = 0, errors = 0;
  int trig_cnt = 0, trig_val = 0, trig_state = 0;

  typedef struct {
    logic fall;
    int   start;
    int   step;
    int   level;
    int   trig;
    int   first;
  } vec_t;
  vec_t vecs[5];

  always #5 sys_clk = ~sys_clk;

  trig_capture dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_en(sample_en), .adc_data(adc_data),
    .trig_level(trig_level), .edge_sel(edge_sel), .arm(arm), .single_mode(single_mode),
    .stop(stop), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .triggered(triggered), .state(state)
  );

  // sample source: one strobe every 4 cycles, value fstart + k*fstep
  initial begin
    int k, ph;
    k = 0;
    ph = 0;
    sample_en = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (!feed_on) begin
        ph = 0;
        k = 0;
        sample_en = 1'b0;
      end else begin
        ph++;
        sample_en = (ph % 4 == 0);
        if (sample_en) begin
          adc_data = 12'(fstart + k * fstep);
          k++;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (triggered) begin
      trig_cnt   <= trig_cnt + 1;
      trig_val   <= int'(adc_data);
      trig_state <= int'(state);
    end
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic read_window(input int exp_first, input int step, input logic rnd, input int max_words);
    int n, seq_err, last_err, proto_err, cyc, read_cyc, valid_cyc, e;
    logic stalled, gap, gap2, held_l, fin;
    logic [11:0] held_d;
    n = 0; seq_err = 0; last_err = 0; proto_err = 0; cyc = 0; read_cyc = -1; valid_cyc = -1;
    stalled = 0; gap = 0; gap2 = 0; held_l = 0; held_d = '0; fin = 0;
    rd_ready = 1'b1;
    while (!fin && cyc < 8000) begin
      @(negedge sys_clk);
      cyc++;
      if (state == 3'd4 && read_cyc < 0) read_cyc = cyc;
      if (rd_valid && valid_cyc < 0) valid_cyc = cyc;
      if (stalled && !(rd_valid && rd_data == held_d && rd_last == held_l)) proto_err++;
      if (gap && rd_valid) proto_err++;
      if (gap2 && !rd_valid) proto_err++;
      gap2 = gap;
      gap = 0;
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      stalled = rd_valid && !rd_ready;
      held_d = rd_data;
      held_l = rd_last;
      if (rd_valid && rd_ready) begin
        e = exp_first + n * step;
        if (rd_data != e[11:0]) seq_err++;
        if (rd_last != (n == 255)) last_err++;
        n++;
        gap = 1;
        if (rd_last || n == max_words) fin = 1;
      end
    end
    @(posedge sys_clk);
    #1;
    check("window_done", int'(fin), 1);
    check("word_count", n, max_words);
    check("word_values", seq_err, 0);
    check("rd_last_position", last_err, 0);
    check("handshake", proto_err, 0);
    check("read_latency", valid_cyc - read_cyc, 2);
  endtask

  task automatic start_capture(input vec_t v, input logic single);
    @(posedge sys_clk);
    #1;
    feed_on = 0;
    edge_sel = v.fall;
    trig_level = 12'(v.level);
    fstart = v.start;
    fstep = v.step;
    single_mode = single;
    arm = 1;
    @(posedge sys_clk);
    #1;
    arm = 0;
    feed_on = 1;
  endtask

  task automatic run_vec(input vec_t v, input logic rnd, input logic single);
    int t0;
    t0 = trig_cnt;
    start_capture(v, single);
    read_window(v.first, v.step, rnd, 256);
    check("trig_count", trig_cnt - t0, 1);
    check("trig_value", trig_val, v.trig);
    check("trig_state", trig_state, 3);
  endtask

  initial begin
    int t0, w;
    vecs[0] = '{1'b0, 0, 1, 100, 100, 36};
    vecs[1] = '{1'b1, 400, -1, 200, 200, 264};
    vecs[2] = '{1'b0, 4000, 1, 4090, 4090, 4026};
    vecs[3] = '{1'b0, 0, 3, 200, 201, 9};
    vecs[4] = '{1'b1, 1000, -7, 500, 496, 944};
    rst_n = 0; arm = 0; stop = 0; single_mode = 1; edge_sel = 0; trig_level = '0;
    rd_ready = 0; feed_on = 0; fstart = 0; fstep = 0;
    #12;
    check("reset_state", int'(state), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_rd_last", int'(rd_last), 0);
    check("reset_triggered", int'(triggered), 0);
    @(posedge sys_clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], 1'b0, 1'b1);
      repeat (2) @(posedge sys_clk);
      #1;
      check("single_idle", int'(state), 0);
      check("single_no_valid", int'(rd_valid), 0);
    end
    run_vec(vecs[0], 1'b1, 1'b1);
    repeat (2) @(posedge sys_clk);
    #1;
    check("stall_idle", int'(state), 0);

    run_vec(vecs[0], 1'b0, 1'b0);
    check("auto_rearm_pre", int'(state), 1);
    w = 0;
    do begin @(negedge sys_clk); w++; end while (state != 3'd2 && w < 400);
    check("auto_reach_wait", int'(state), 2);
    @(posedge sys_clk);
    #1;
    stop = 1;
    @(posedge sys_clk);
    #1;
    check("stop_to_idle", int'(state), 0);
    arm = 1;
    @(posedge sys_clk);
    #1;
    arm = 0;
    check("arm_with_stop", int'(state), 0);
    w = 0;
    for (int i = 0; i < 20; i++) begin @(negedge sys_clk); if (rd_valid) w++; end
    check("stop_no_valid", w, 0);
    stop = 0;
    single_mode = 1;

    t0 = trig_cnt;
    start_capture('{1'b0, 100, 0, 100, 0, 0}, 1'b1);
    repeat (656) @(posedge sys_clk);
    #1;
    check("flat_in_wait", int'(state), 2);
    check("flat_no_trigger", trig_cnt - t0, 0);
    arm = 1;
    @(posedge sys_clk);
    #1;
    arm = 0;
    @(posedge sys_clk);
    #1;
    check("arm_in_wait", int'(state), 2);
    stop = 1;
    @(posedge sys_clk);
    #1;
    stop = 0;
    check("flat_stop_idle", int'(state), 0);

    start_capture(vecs[0], 1'b1);
    read_window(36, 1, 1'b0, 10);
    w = 0;
    do begin @(negedge sys_clk); w++; end while (!rd_valid && w < 8);
    check("valid_before_reset", int'(rd_valid), 1);
    rst_n = 0;
    #1;
    check("async_rd_valid", int'(rd_valid), 0);
    check("async_rd_data", int'(rd_data), 0);
    check("async_rd_last", int'(rd_last), 0);
    check("async_triggered", int'(triggered), 0);
    check("async_state", int'(state), 0);
    feed_on = 0;
    @(posedge sys_clk);
    #3;
    rst_n = 1;
    run_vec(vecs[0], 1'b0, 1'b1);
    repeat (2) @(posedge sys_clk);
    #1;
    check("rearm_idle", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
